udp_tx_encap: RTL and testbench
===============================

Name: udp_tx_encap

Overview:
UDP transmit encapsulation stage. It sits between the user UDP TX interface (udp_tx_type header plus axi_out_type byte stream) and the IPv4 TX block (ipv4_tx_type).
- Latches the UDP header on start.
- Requests an IPv4 transmit with protocol 17 and length = data_length+8.
- Emits the 8-byte UDP header, then passes user payload bytes through under downstream backpressure.
- Reports UDPTX_RESULT_* status to the user.

Parameters:
PROTOCOL_UDP, 8'h11, IPv4 protocol field driven on ip_tx_protocol.
MAX_DATA_LEN, 65507, largest accepted data_length in bytes; larger values are rejected.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
udp_tx_start  in  1  request to send; sampled only in IDLE
udp_tx_dst_ip_addr  in  32  destination IP address
udp_tx_dst_port  in  16  destination port
udp_tx_src_port  in  16  source port
udp_tx_data_length  in  16  payload length in bytes, excluding UDP header
udp_tx_checksum  in  16  UDP checksum, sent verbatim (0 = none)
udp_tx_data_out  in  8  payload byte
udp_tx_data_out_valid  in  1  payload byte valid
udp_tx_data_out_last  in  1  last payload byte
udp_tx_data_out_ready  out  1  stage accepts payload byte
udp_tx_result  out  2  UDPTX_RESULT_NONE/SENDING/ERR/SENT
ip_tx_start  out  1  IPv4 send request
ip_tx_protocol  out  8  = PROTOCOL_UDP
ip_tx_data_length  out  16  UDP length = data_length+8
ip_tx_dst_ip_addr  out  32  latched destination IP
ip_tx_data_out  out  8  byte to IPv4 stage
ip_tx_data_out_valid  out  1  byte valid
ip_tx_data_out_last  out  1  last byte of UDP datagram
ip_tx_data_out_ready  in  1  IPv4 stage accepts byte
ip_tx_result  in  2  IPTX_RESULT_* from IPv4 stage

Behaviour:
- Reset (async, any state): state IDLE, all outputs 0, udp_tx_result = NONE (0), counters and latched header cleared. No partial frame is resumed.
- A transfer occurs on any cycle where valid & ready are both 1, on both the user and IP sides.
- IDLE:
  - udp_tx_start=1 and data_length <= MAX_DATA_LEN → latch header; next cycle: state SEND_HDR, result = SENDING, ip_tx_start = 1.
  - data_length > MAX_DATA_LEN → next cycle result = ERR; state stays IDLE; ip_tx_start stays 0.
- SEND_HDR:
  - ip_tx_data_out_valid = 1. A 3-bit hdr_cnt selects bytes in this order: src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], len[15:8], len[7:0], checksum[15:8], checksum[7:0], where len = data_length+8 (16-bit, no overflow by MAX_DATA_LEN).
  - hdr_cnt advances on each transfer.
  - ip_tx_start drops after the first header byte is transferred.
  - udp_tx_data_out_ready = 0 throughout.
  - After byte 7 transfers: data_length = 0 → byte 7 carries last = 1, next state DONE; otherwise next state SEND_DATA, payload counter = 0.
- SEND_DATA, zero-latency pass-through:
  - ip_tx_data_out = udp_tx_data_out, ip_tx_data_out_valid = udp_tx_data_out_valid, udp_tx_data_out_ready = ip_tx_data_out_ready.
  - The payload counter increments per transfer.
  - ip_tx_data_out_last = 1 when counter = data_length-1 or when upstream last = 1.
  - On a transfer with that last flag: if counter = data_length-1 and upstream last = 1, next state DONE with result SENT. Any mismatch (early upstream last, or count reached without upstream last) → next state DONE with result ERR.
  - After a forced last, the stage takes no further upstream bytes until a new start.
- DONE: lasts one cycle, then IDLE. Result holds SENT/ERR until the next accepted start.
- ip_tx_result = IPTX_RESULT_ERR in SEND_HDR or SEND_DATA → result ERR, all valid/ready outputs drop, next state IDLE.
- udp_tx_start outside IDLE is ignored.
- ip_tx_protocol, ip_tx_data_length and ip_tx_dst_ip_addr are stable from ip_tx_start until return to IDLE.

Test Plan:
- Basic send, ready always 1: src 0x1234, dst 0x0050, dst_ip 0xC0A80001, length 3, checksum 0, payload AA BB CC(last) → IP bytes 12 34 00 50 00 0B 00 00 AA BB CC, last on CC, ip_tx_data_length = 11, protocol = 0x11, result SENDING then SENT.
- Backpressure: same frame with ip_tx_data_out_ready toggling 1/0 each cycle → identical byte order, no duplication or loss, udp_tx_data_out_ready mirrors the IP ready in SEND_DATA.
- Zero-length: length 0 → exactly 8 header bytes, last on byte 7 (length field 00 08), result SENT, udp_tx_data_out_ready never 1.
- Length errors:
  - Length 4 with last on the 2nd byte → last forwarded on byte 2, result ERR.
  - Length 2 with no upstream last → last forced on the 2nd byte, result ERR.
  - Length 65508 → result ERR, ip_tx_start never asserted.
- Mid-frame reset: assert reset during payload byte 1 of 5 → all outputs 0 and result NONE immediately. A following start sends a full new frame beginning with the header.
- Downstream error and busy start: ip_tx_result = ERR during SEND_HDR → result ERR, return to IDLE. A second udp_tx_start pulsed during SEND_DATA of another frame has no effect.

Source files
------------

// File: rtl/udp_tx_encap_if.sv
// Signal bundle between the user UDP TX side, the encapsulation stage and the IPv4 TX side.
interface udp_tx_encap_if;
  // User side: header plus payload byte stream
  logic        udp_tx_start;
  logic [31:0] udp_tx_dst_ip_addr;
  logic [15:0] udp_tx_dst_port;
  logic [15:0] udp_tx_src_port;
  logic [15:0] udp_tx_data_length;
  logic [15:0] udp_tx_checksum;
  logic [7:0]  udp_tx_data_out;
  logic        udp_tx_data_out_valid;
  logic        udp_tx_data_out_last;
  logic        udp_tx_data_out_ready;
  logic [1:0]  udp_tx_result;
  // IPv4 side: transmit request plus datagram byte stream
  logic        ip_tx_start;
  logic [7:0]  ip_tx_protocol;
  logic [15:0] ip_tx_data_length;
  logic [31:0] ip_tx_dst_ip_addr;
  logic [7:0]  ip_tx_data_out;
  logic        ip_tx_data_out_valid;
  logic        ip_tx_data_out_last;
  logic        ip_tx_data_out_ready;
  logic [1:0]  ip_tx_result;

  // Encapsulation stage view
  modport slave (
    input  udp_tx_start, udp_tx_dst_ip_addr, udp_tx_dst_port, udp_tx_src_port,
    input  udp_tx_data_length, udp_tx_checksum, udp_tx_data_out, udp_tx_data_out_valid,
    input  udp_tx_data_out_last, ip_tx_data_out_ready, ip_tx_result,
    output udp_tx_data_out_ready, udp_tx_result, ip_tx_start, ip_tx_protocol,
    output ip_tx_data_length, ip_tx_dst_ip_addr, ip_tx_data_out, ip_tx_data_out_valid,
    output ip_tx_data_out_last
  );

  // Environment view: drives the user side and the IPv4 ready/result
  modport master (
    output udp_tx_start, udp_tx_dst_ip_addr, udp_tx_dst_port, udp_tx_src_port,
    output udp_tx_data_length, udp_tx_checksum, udp_tx_data_out, udp_tx_data_out_valid,
    output udp_tx_data_out_last, ip_tx_data_out_ready, ip_tx_result,
    input  udp_tx_data_out_ready, udp_tx_result, ip_tx_start, ip_tx_protocol,
    input  ip_tx_data_length, ip_tx_dst_ip_addr, ip_tx_data_out, ip_tx_data_out_valid,
    input  ip_tx_data_out_last
  );
endinterface

// File: rtl/udp_tx_encap.sv
// UDP transmit encapsulation: latches the user header, requests an IPv4 send,
// emits the 8-byte UDP header and then passes the payload straight through.
module udp_tx_encap #(
  parameter logic [7:0]  PROTOCOL_UDP = 8'h11,
  parameter int unsigned MAX_DATA_LEN = 65507
) (
  input  logic          clk,
  input  logic          reset,
  udp_tx_encap_if.slave bus
);
  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StSendHdr  = 2'd1;
  localparam logic [1:0] StSendData = 2'd2;
  localparam logic [1:0] StDone     = 2'd3;

  localparam logic [1:0] ResNone    = 2'd0;
  localparam logic [1:0] ResSending = 2'd1;
  localparam logic [1:0] ResErr     = 2'd2;
  localparam logic [1:0] ResSent    = 2'd3;
  localparam logic [1:0] IpTxErr    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [1:0]  result_q, result_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [15:0] data_len_q, data_len_d;
  logic [15:0] checksum_q, checksum_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [7:0]  protocol_q, protocol_d;

  logic        ip_err, len_ok, cnt_at_end, data_last, ip_xfer;
  logic        ip_start, ip_valid, ip_last, usr_ready;
  logic [7:0]  ip_data, hdr_byte;

  // A downstream error only matters while a frame is in flight
  assign ip_err     = ((state_q == StSendHdr) || (state_q == StSendData)) &&
                      (bus.ip_tx_result == IpTxErr);
  assign len_ok     = 32'(bus.udp_tx_data_length) <= MAX_DATA_LEN;
  assign cnt_at_end = pay_cnt_q == (data_len_q - 16'd1);
  assign data_last  = cnt_at_end || bus.udp_tx_data_out_last;
  assign ip_xfer    = ip_valid && bus.ip_tx_data_out_ready;

  // Header byte selected by hdr_cnt, network byte order
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt_q)
      3'd0:    hdr_byte = src_port_q[15:8];
      3'd1:    hdr_byte = src_port_q[7:0];
      3'd2:    hdr_byte = dst_port_q[15:8];
      3'd3:    hdr_byte = dst_port_q[7:0];
      3'd4:    hdr_byte = udp_len_q[15:8];
      3'd5:    hdr_byte = udp_len_q[7:0];
      3'd6:    hdr_byte = checksum_q[15:8];
      default: hdr_byte = checksum_q[7:0];
    endcase
  end

  // Output stream: header from registers, payload as a zero-latency pass-through
  always_comb begin
    ip_start  = 1'b0;
    ip_valid  = 1'b0;
    ip_last   = 1'b0;
    ip_data   = 8'h00;
    usr_ready = 1'b0;
    case (state_q)
      StSendHdr: if (!ip_err) begin
        ip_valid = 1'b1;
        ip_start = hdr_cnt_q == 3'd0;
        ip_data  = hdr_byte;
        ip_last  = (hdr_cnt_q == 3'd7) && (data_len_q == 16'd0);
      end
      StSendData: if (!ip_err) begin
        ip_data   = bus.udp_tx_data_out;
        ip_valid  = bus.udp_tx_data_out_valid;
        usr_ready = bus.ip_tx_data_out_ready;
        ip_last   = bus.udp_tx_data_out_valid && data_last;
      end
      default: ;
    endcase
  end

  // Frame sequencing, header latch and status
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    result_d   = result_q;
    src_port_d = src_port_q;
    dst_port_d = dst_port_q;
    data_len_d = data_len_q;
    checksum_d = checksum_q;
    udp_len_d  = udp_len_q;
    dst_ip_d   = dst_ip_q;
    protocol_d = protocol_q;
    case (state_q)
      StIdle: if (bus.udp_tx_start) begin
        if (len_ok) begin
          src_port_d = bus.udp_tx_src_port;
          dst_port_d = bus.udp_tx_dst_port;
          data_len_d = bus.udp_tx_data_length;
          checksum_d = bus.udp_tx_checksum;
          udp_len_d  = bus.udp_tx_data_length + 16'd8;
          dst_ip_d   = bus.udp_tx_dst_ip_addr;
          protocol_d = PROTOCOL_UDP;
          hdr_cnt_d  = 3'd0;
          result_d   = ResSending;
          state_d    = StSendHdr;
        end else begin
          result_d = ResErr;
        end
      end
      StSendHdr: begin
        if (ip_err) begin
          result_d = ResErr;
          state_d  = StIdle;
        end else if (ip_xfer) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'd7) begin
            if (data_len_q == 16'd0) begin
              result_d = ResSent;
              state_d  = StDone;
            end else begin
              pay_cnt_d = 16'd0;
              state_d   = StSendData;
            end
          end
        end
      end
      StSendData: begin
        if (ip_err) begin
          result_d = ResErr;
          state_d  = StIdle;
        end else if (ip_xfer) begin
          pay_cnt_d = pay_cnt_q + 16'd1;
          if (data_last) begin
            // Length and upstream last must agree, otherwise the frame is bad
            result_d = (cnt_at_end && bus.udp_tx_data_out_last) ? ResSent : ResErr;
            state_d  = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, all cleared by asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hdr_cnt_q  <= 3'd0;
      pay_cnt_q  <= 16'd0;
      result_q   <= ResNone;
      src_port_q <= 16'd0;
      dst_port_q <= 16'd0;
      data_len_q <= 16'd0;
      checksum_q <= 16'd0;
      udp_len_q  <= 16'd0;
      dst_ip_q   <= 32'd0;
      protocol_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      result_q   <= result_d;
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
      data_len_q <= data_len_d;
      checksum_q <= checksum_d;
      udp_len_q  <= udp_len_d;
      dst_ip_q   <= dst_ip_d;
      protocol_q <= protocol_d;
    end
  end

  assign bus.udp_tx_data_out_ready = usr_ready;
  assign bus.udp_tx_result         = result_q;
  assign bus.ip_tx_start           = ip_start;
  assign bus.ip_tx_protocol        = protocol_q;
  assign bus.ip_tx_data_length     = udp_len_q;
  assign bus.ip_tx_dst_ip_addr     = dst_ip_q;
  assign bus.ip_tx_data_out        = ip_data;
  assign bus.ip_tx_data_out_valid  = ip_valid;
  assign bus.ip_tx_data_out_last   = ip_last;
endmodule

// File: tb/tb_udp_tx_encap.sv
// Directed bench for udp_tx_encap with a scoreboard of expected IPv4-side bytes.
module tb_udp_tx_encap;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udp_tx_encap_if bus_if ();
  udp_tx_encap dut (.clk(clk), .reset(reset), .bus(bus_if));

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [8:0] exp_q[$];  // {last, data}
  logic [8:0] mon_e;
  bit bp_mode = 1'b0;
  bit mirror_chk = 1'b0;
  int usr_ready_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IPv4-side ready toggles every cycle in backpressure mode
  always @(posedge clk) begin
    #1;
    if (bp_mode) bus_if.ip_tx_data_out_ready = ~bus_if.ip_tx_data_out_ready;
  end

  // Monitor: every IPv4-side transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus_if.ip_tx_data_out_valid && bus_if.ip_tx_data_out_ready) begin
      if (exp_q.size() == 0) begin
        check("ip_byte_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("ip_byte", {23'd0, bus_if.ip_tx_data_out_last, bus_if.ip_tx_data_out},
              {23'd0, mon_e});
      end
    end
    if (mirror_chk && bus_if.udp_tx_data_out_valid)
      check("ready_mirror", 32'(bus_if.udp_tx_data_out_ready),
            32'(bus_if.ip_tx_data_out_ready));
    if (bus_if.udp_tx_data_out_ready) usr_ready_seen++;
  end

  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic start_frame(input logic [15:0] src, input logic [15:0] dst,
                             input logic [31:0] ip, input logic [15:0] len,
                             input logic [15:0] csum, input bit push_hdr);
    logic [15:0] ulen;
    ulen = len + 16'd8;
    @(posedge clk); #1;
    bus_if.udp_tx_src_port    = src;
    bus_if.udp_tx_dst_port    = dst;
    bus_if.udp_tx_dst_ip_addr = ip;
    bus_if.udp_tx_data_length = len;
    bus_if.udp_tx_checksum    = csum;
    bus_if.udp_tx_start       = 1'b1;
    if (push_hdr) begin
      push_exp(src[15:8], 1'b0);  push_exp(src[7:0], 1'b0);
      push_exp(dst[15:8], 1'b0);  push_exp(dst[7:0], 1'b0);
      push_exp(ulen[15:8], 1'b0); push_exp(ulen[7:0], 1'b0);
      push_exp(csum[15:8], 1'b0); push_exp(csum[7:0], len == 16'd0);
    end
    @(posedge clk); #1;
    bus_if.udp_tx_start = 1'b0;
    @(negedge clk);
    check("ip_tx_start_on_entry", 32'(bus_if.ip_tx_start), 32'd1);
    check("result_sending", 32'(bus_if.udp_tx_result), 32'd1);
    check("ip_protocol", 32'(bus_if.ip_tx_protocol), 32'h11);
    check("ip_length", 32'(bus_if.ip_tx_data_length), 32'(ulen));
    check("ip_dst_addr", bus_if.ip_tx_dst_ip_addr, ip);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    bus_if.udp_tx_data_out       = d;
    bus_if.udp_tx_data_out_valid = 1'b1;
    bus_if.udp_tx_data_out_last  = l;
    @(negedge clk);
    while (!bus_if.udp_tx_data_out_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("payload_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    bus_if.udp_tx_data_out_valid = 1'b0;
    bus_if.udp_tx_data_out_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic finish_frame(input string tag, input logic [1:0] res);
    wait_drain();
    repeat (3) @(negedge clk);
    check({tag, "_result"}, 32'(bus_if.udp_tx_result), 32'(res));
    check({tag, "_idle_valid"}, 32'(bus_if.ip_tx_data_out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus_if.udp_tx_data_out_ready), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_if.udp_tx_start = 1'b0;
    bus_if.udp_tx_dst_ip_addr = '0;
    bus_if.udp_tx_dst_port = '0;
    bus_if.udp_tx_src_port = '0;
    bus_if.udp_tx_data_length = '0;
    bus_if.udp_tx_checksum = '0;
    bus_if.udp_tx_data_out = '0;
    bus_if.udp_tx_data_out_valid = 1'b0;
    bus_if.udp_tx_data_out_last = 1'b0;
    bus_if.ip_tx_data_out_ready = 1'b1;
    bus_if.ip_tx_result = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_result", 32'(bus_if.udp_tx_result), 32'd0);
    check("rst_ip_start", 32'(bus_if.ip_tx_start), 32'd0);
    check("rst_ip_valid", 32'(bus_if.ip_tx_data_out_valid), 32'd0);
    check("rst_usr_ready", 32'(bus_if.udp_tx_data_out_ready), 32'd0);
    check("rst_protocol", 32'(bus_if.ip_tx_protocol), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic frame, ready always high
    start_frame(16'h1234, 16'h0050, 32'hC0A80001, 16'd3, 16'h0000, 1'b1);
    check("basic_ip_length_11", 32'(bus_if.ip_tx_data_length), 32'd11);
    @(negedge clk);
    check("ip_start_drops", 32'(bus_if.ip_tx_start), 32'd0);
    push_exp(8'hAA, 1'b0); push_exp(8'hBB, 1'b0); push_exp(8'hCC, 1'b1);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
    finish_frame("basic", 2'd3);

    // Same frame under toggling downstream ready
    bp_mode = 1'b1;
    start_frame(16'h1234, 16'h0050, 32'hC0A80001, 16'd3, 16'h0000, 1'b1);
    wait_drain();
    @(posedge clk); #1;
    mirror_chk = 1'b1;
    push_exp(8'hAA, 1'b0); push_exp(8'hBB, 1'b0); push_exp(8'hCC, 1'b1);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
    mirror_chk = 1'b0;
    finish_frame("backpressure", 2'd3);
    bp_mode = 1'b0;
    @(posedge clk); #2;
    bus_if.ip_tx_data_out_ready = 1'b1;

    // Zero-length datagram: header only, last on byte 7
    usr_ready_seen = 0;
    start_frame(16'h0A0B, 16'h0C0D, 32'h0A000001, 16'd0, 16'h5A5A, 1'b1);
    finish_frame("zero_len", 2'd3);
    check("zero_len_no_usr_ready", 32'(usr_ready_seen), 32'd0);

    // Early upstream last
    start_frame(16'h1111, 16'h2222, 32'h01020304, 16'd4, 16'h0000, 1'b1);
    push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b1);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
    finish_frame("early_last", 2'd2);

    // Count reached without upstream last: last is forced
    start_frame(16'h3333, 16'h4444, 32'h05060708, 16'd2, 16'h0000, 1'b1);
    push_exp(8'h33, 1'b0); push_exp(8'h44, 1'b1);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    finish_frame("forced_last", 2'd2);

    // Oversized length is rejected without an IPv4 request
    @(posedge clk); #1;
    bus_if.udp_tx_data_length = 16'd65508;
    bus_if.udp_tx_start = 1'b1;
    @(negedge clk);
    check("oversize_no_start_a", 32'(bus_if.ip_tx_start), 32'd0);
    @(posedge clk); #1;
    bus_if.udp_tx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("oversize_no_start", 32'(bus_if.ip_tx_start), 32'd0);
      check("oversize_result", 32'(bus_if.udp_tx_result), 32'd2);
    end

    // Reset in the middle of the payload, then a fresh frame
    start_frame(16'hA1A2, 16'hB1B2, 32'hC1C2C3C4, 16'd5, 16'h0000, 1'b1);
    push_exp(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    bus_if.udp_tx_data_out = 8'h02;
    bus_if.udp_tx_data_out_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("midrst_ip_start", 32'(bus_if.ip_tx_start), 32'd0);
    check("midrst_ip_valid", 32'(bus_if.ip_tx_data_out_valid), 32'd0);
    check("midrst_ip_last", 32'(bus_if.ip_tx_data_out_last), 32'd0);
    check("midrst_ip_data", 32'(bus_if.ip_tx_data_out), 32'd0);
    check("midrst_usr_ready", 32'(bus_if.udp_tx_data_out_ready), 32'd0);
    check("midrst_result", 32'(bus_if.udp_tx_result), 32'd0);
    check("midrst_length", 32'(bus_if.ip_tx_data_length), 32'd0);
    check("midrst_dst_ip", bus_if.ip_tx_dst_ip_addr, 32'd0);
    exp_q.delete();
    bus_if.udp_tx_data_out_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    start_frame(16'h7788, 16'h99AA, 32'h0B0B0B0B, 16'd1, 16'h1234, 1'b1);
    push_exp(8'h5A, 1'b1);
    send_byte(8'h5A, 1'b1);
    finish_frame("after_reset", 2'd3);

    // Downstream error while the header is stalled
    bus_if.ip_tx_data_out_ready = 1'b0;
    start_frame(16'h0001, 16'h0002, 32'h0D0D0D0D, 16'd3, 16'h0000, 1'b0);
    bus_if.ip_tx_result = 2'd2;
    #1;
    check("ip_err_valid_drop", 32'(bus_if.ip_tx_data_out_valid), 32'd0);
    check("ip_err_start_drop", 32'(bus_if.ip_tx_start), 32'd0);
    @(posedge clk); #1;
    bus_if.ip_tx_result = 2'd0;
    bus_if.ip_tx_data_out_ready = 1'b1;
    @(negedge clk);
    check("ip_err_result", 32'(bus_if.udp_tx_result), 32'd2);
    check("ip_err_idle", 32'(bus_if.ip_tx_data_out_valid), 32'd0);

    // A start pulsed mid-payload is ignored
    start_frame(16'h0101, 16'h0202, 32'h0E0E0E0E, 16'd3, 16'hBEEF, 1'b1);
    push_exp(8'hD1, 1'b0); push_exp(8'hD2, 1'b0); push_exp(8'hD3, 1'b1);
    send_byte(8'hD1, 1'b0);
    bus_if.udp_tx_src_port = 16'hDEAD;
    bus_if.udp_tx_data_length = 16'd1;
    bus_if.udp_tx_start = 1'b1;
    send_byte(8'hD2, 1'b0);
    bus_if.udp_tx_start = 1'b0;
    send_byte(8'hD3, 1'b1);
    finish_frame("busy_start", 2'd3);
    check("busy_start_no_request", 32'(bus_if.ip_tx_start), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
